// File: rtl/sa_pkg.sv
// Shared types and constants for the systolic-array result writer.
package sa_pkg;

    localparam int DATA_W  = 8;
    localparam int ADDR_W  = 6;
    localparam int SAT_MAX = 127;
    localparam int SAT_MIN = -128;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } wb_state_t;

endpackage

// File: rtl/sat_add8.sv
// Combinational signed saturating adder: y = clamp(a + b, SAT_MIN, SAT_MAX).
module sat_add8
    import sa_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] y
);

    logic [DATA_W:0] sum;

    // One extra bit of headroom; a mismatch between the top two bits means
    // the true sum left the representable range, and the top bit gives the sign.
    always_comb begin
        sum = {a[DATA_W-1], a} + {b[DATA_W-1], b};
        y   = sum[DATA_W-1:0];
        if (sum[DATA_W] != sum[DATA_W-1]) begin
            y = sum[DATA_W] ? DATA_W'(SAT_MIN) : DATA_W'(SAT_MAX);
        end
    end

endmodule

// File: rtl/sa_result_writer.sv
// Write-back stage behind the 2x2 systolic array: snapshots c11..c22 on start,
// optionally accumulates into RAM (read-modify-write), optionally applies ReLU,
// and writes four consecutive RAM words starting at out_baseaddr.
//
// Handshake: start is a level sampled only in IDLE; a start seen in any other
// state is dropped, not queued. busy is high for every cycle that drives the
// RAM (RD and WR), and is_done_o pulses for exactly one cycle after the fourth
// write. All operands are captured with start, so later input changes are ignored.
module sa_result_writer
    import sa_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] c11,
    input  logic [DATA_W-1:0] c12,
    input  logic [DATA_W-1:0] c21,
    input  logic [DATA_W-1:0] c22,
    input  logic [ADDR_W-1:0] out_baseaddr,
    input  logic              acc_en,
    input  logic              relu_en,
    input  logic [DATA_W-1:0] ram_q,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_we,
    output logic              busy,
    output logic              is_done_o
);

    wb_state_t         state;
    wb_state_t         state_nxt;
    logic [1:0]        idx;
    logic [DATA_W-1:0] buf_q [4];
    logic [ADDR_W-1:0] base_q;
    logic              acc_q;
    logic              relu_q;

    logic [DATA_W-1:0] cur_elem;
    logic [DATA_W-1:0] acc_sum;
    logic [DATA_W-1:0] pre_relu;
    logic [DATA_W-1:0] result;
    logic [ADDR_W-1:0] elem_addr;

    // State register plus operand capture and element index advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            idx    <= 2'd0;
            base_q <= '0;
            acc_q  <= 1'b0;
            relu_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                buf_q[0] <= c11;
                buf_q[1] <= c12;
                buf_q[2] <= c21;
                buf_q[3] <= c22;
                base_q   <= out_baseaddr;
                acc_q    <= acc_en;
                relu_q   <= relu_en;
                idx      <= 2'd0;
            end else if (state == WR && idx != 2'd3) begin
                idx <= idx + 2'd1;
            end
        end
    end

    // Next-state decode: accumulate runs alternate RD/WR, plain runs stay in WR.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (start) state_nxt = acc_en ? RD : WR;
            RD:   state_nxt = WR;
            WR:   if (idx == 2'd3) state_nxt = DONE;
                  else             state_nxt = acc_q ? RD : WR;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    sat_add8 u_sat_add (
        .a (cur_elem),
        .b (ram_q),
        .y (acc_sum)
    );

    // Write data path: ram_q here is the word fetched by the preceding RD cycle.
    always_comb begin
        cur_elem  = buf_q[idx];
        pre_relu  = acc_q ? acc_sum : cur_elem;
        result    = (relu_q && pre_relu[DATA_W-1]) ? '0 : pre_relu;
        elem_addr = base_q + ADDR_W'(idx);
    end

    // Moore output decode; idle values apply wherever a state does not drive a signal.
    always_comb begin
        ram_addr  = '0;
        ram_data  = '0;
        ram_we    = 1'b0;
        busy      = 1'b0;
        is_done_o = 1'b0;
        unique case (state)
            RD: begin
                ram_addr = elem_addr;
                busy     = 1'b1;
            end
            WR: begin
                ram_addr = elem_addr;
                ram_data = result;
                ram_we   = 1'b1;
                busy     = 1'b1;
            end
            DONE:    is_done_o = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sa_result_writer.sv
// Directed testbench for sa_result_writer with a behavioural single-port RAM.
module tb_sa_result_writer;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start;
    logic [7:0] c11, c12, c21, c22;
    logic [5:0] out_baseaddr;
    logic       acc_en;
    logic       relu_en;
    logic [7:0] ram_q;
    logic [5:0] ram_addr;
    logic [7:0] ram_data;
    logic       ram_we;
    logic       busy;
    logic       is_done_o;

    sa_result_writer dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .c11          (c11),
        .c12          (c12),
        .c21          (c21),
        .c22          (c22),
        .out_baseaddr (out_baseaddr),
        .acc_en       (acc_en),
        .relu_en      (relu_en),
        .ram_q        (ram_q),
        .ram_addr     (ram_addr),
        .ram_data     (ram_data),
        .ram_we       (ram_we),
        .busy         (busy),
        .is_done_o    (is_done_o)
    );

    // ---------------- RAM model with preload port and write log ----------------
    logic [7:0]  mem [64];
    logic        pre_we;
    logic [5:0]  pre_addr;
    logic [7:0]  pre_data;
    logic [13:0] wr_q [$];
    logic [13:0] exp_q [$];

    always @(posedge clk) begin
        if (pre_we) begin
            mem[pre_addr] <= pre_data;
        end else if (ram_we) begin
            mem[ram_addr] <= ram_data;
            wr_q.push_back({ram_addr, ram_data});
        end
        ram_q <= mem[ram_addr];
    end

    // ---------------- scoreboard ----------------
    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic we, input logic [5:0] addr,
                             input logic [7:0] data, input logic bsy, input logic done);
        chk({tag, ".we"},   32'(ram_we),    32'(we));
        chk({tag, ".addr"}, 32'(ram_addr),  32'(addr));
        chk({tag, ".data"}, 32'(ram_data),  32'(data));
        chk({tag, ".busy"}, 32'(busy),      32'(bsy));
        chk({tag, ".done"}, 32'(is_done_o), 32'(done));
    endtask

    task automatic check_writes(input string tag);
        int n;
        chk({tag, ".nwrites"}, 32'(wr_q.size()), 32'(exp_q.size()));
        n = (wr_q.size() < exp_q.size()) ? wr_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s.write%0d", tag, i), 32'(wr_q[i]), 32'(exp_q[i]));
        end
        wr_q.delete();
        exp_q.delete();
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [5:0] a, input logic [7:0] d);
        pre_we   = 1'b1;
        pre_addr = a;
        pre_data = d;
        step();
        pre_we   = 1'b0;
    endtask

    task automatic issue(input logic [5:0] base, input logic acc, input logic relu,
                         input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] d);
        c11 = a; c12 = b; c21 = c; c22 = d;
        out_baseaddr = base;
        acc_en  = acc;
        relu_en = relu;
        start   = 1'b1;
    endtask

    // Scramble operands after the start cycle; the DUT must not see them.
    task automatic scramble();
        start = 1'b0;
        c11 = 8'($urandom_range(0, 255));
        c12 = 8'($urandom_range(0, 255));
        c21 = 8'($urandom_range(0, 255));
        c22 = 8'($urandom_range(0, 255));
        out_baseaddr = 6'($urandom_range(0, 63));
        acc_en  = 1'($urandom_range(0, 1));
        relu_en = 1'($urandom_range(0, 1));
    endtask

    // ---------------- directed sequence ----------------
    logic [7:0] e1 [4];
    logic [7:0] e2 [4];
    logic [7:0] e3 [4];
    logic [7:0] e4 [4];
    logic [7:0] e5 [4];

    initial begin
        rst = 1'b1; start = 1'b0; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        c11 = '0; c12 = '0; c21 = '0; c22 = '0;
        out_baseaddr = '0; acc_en = 1'b0; relu_en = 1'b0;
        for (int i = 0; i < 64; i++) begin
            pre_we = 1'b1; pre_addr = 6'(i); pre_data = 8'h00;
            step();
        end
        pre_we = 1'b0;
        check_out("reset", 1'b0, 6'd0, 8'd0, 1'b0, 1'b0);
        rst = 1'b0;
        step();
        check_out("idle", 1'b0, 6'd0, 8'd0, 1'b0, 1'b0);

        // Test 1: plain write-back, c = (5, -3, 127, 0) at base 10.
        e1 = '{8'd5, 8'hFD, 8'd127, 8'd0};
        issue(6'd10, 1'b0, 1'b0, 8'd5, 8'hFD, 8'd127, 8'd0);
        step();
        scramble();
        for (int i = 0; i < 4; i++) begin
            check_out($sformatf("t1.wr%0d", i), 1'b1, 6'(10 + i), e1[i], 1'b1, 1'b0);
            exp_q.push_back({6'(10 + i), e1[i]});
            step();
        end
        check_out("t1.done", 1'b0, 6'd0, 8'd0, 1'b0, 1'b1);
        step();
        check_out("t1.idle", 1'b0, 6'd0, 8'd0, 1'b0, 1'b0);
        check_writes("t1");

        // Test 2: accumulate with saturation at base 20.
        preload(6'd20, 8'd100);
        preload(6'd21, 8'h9C);
        preload(6'd22, 8'd1);
        preload(6'd23, 8'h80);
        e2 = '{8'd127, 8'h80, 8'd3, 8'h80};
        issue(6'd20, 1'b1, 1'b0, 8'd100, 8'h9C, 8'd2, 8'hFF);
        step();
        scramble();
        for (int i = 0; i < 4; i++) begin
            check_out($sformatf("t2.rd%0d", i), 1'b0, 6'(20 + i), 8'd0, 1'b1, 1'b0);
            step();
            check_out($sformatf("t2.wr%0d", i), 1'b1, 6'(20 + i), e2[i], 1'b1, 1'b0);
            exp_q.push_back({6'(20 + i), e2[i]});
            step();
        end
        check_out("t2.done", 1'b0, 6'd0, 8'd0, 1'b0, 1'b1);
        step();
        check_out("t2.idle", 1'b0, 6'd0, 8'd0, 1'b0, 1'b0);
        check_writes("t2");

        // Test 3: ReLU without accumulation, c = (-1, 4, -128, 7) at base 30.
        e3 = '{8'd0, 8'd4, 8'd0, 8'd7};
        issue(6'd30, 1'b0, 1'b1, 8'hFF, 8'd4, 8'h80, 8'd7);
        step();
        scramble();
        for (int i = 0; i < 4; i++) begin
            check_out($sformatf("t3.wr%0d", i), 1'b1, 6'(30 + i), e3[i], 1'b1, 1'b0);
            exp_q.push_back({6'(30 + i), e3[i]});
            step();
        end
        check_out("t3.done", 1'b0, 6'd0, 8'd0, 1'b0, 1'b1);
        step();
        check_writes("t3");

        // Test 4: address wrap from 62, ignored start in cycle 2, back-to-back start in cycle 6.
        e4 = '{8'd1, 8'd2, 8'd3, 8'd4};
        issue(6'd62, 1'b0, 1'b0, 8'd1, 8'd2, 8'd3, 8'd4);
        step();
        start = 1'b0;
        check_out("t4.wr0", 1'b1, 6'd62, e4[0], 1'b1, 1'b0);
        exp_q.push_back({6'd62, e4[0]});
        step();
        check_out("t4.wr1", 1'b1, 6'd63, e4[1], 1'b1, 1'b0);
        exp_q.push_back({6'd63, e4[1]});
        issue(6'd5, 1'b1, 1'b1, 8'h11, 8'h11, 8'h11, 8'h11);
        step();
        start = 1'b0;
        check_out("t4.wr2", 1'b1, 6'd0, e4[2], 1'b1, 1'b0);
        exp_q.push_back({6'd0, e4[2]});
        step();
        check_out("t4.wr3", 1'b1, 6'd1, e4[3], 1'b1, 1'b0);
        exp_q.push_back({6'd1, e4[3]});
        step();
        check_out("t4.done", 1'b0, 6'd0, 8'd0, 1'b0, 1'b1);
        step();
        check_out("t4.idle", 1'b0, 6'd0, 8'd0, 1'b0, 1'b0);
        e5 = '{8'd9, 8'd8, 8'd7, 8'd6};
        issue(6'd40, 1'b0, 1'b0, 8'd9, 8'd8, 8'd7, 8'd6);
        step();
        scramble();
        for (int i = 0; i < 4; i++) begin
            check_out($sformatf("t4b.wr%0d", i), 1'b1, 6'(40 + i), e5[i], 1'b1, 1'b0);
            exp_q.push_back({6'(40 + i), e5[i]});
            step();
        end
        check_out("t4b.done", 1'b0, 6'd0, 8'd0, 1'b0, 1'b1);
        step();
        check_writes("t4");

        // Test 5: reset during the second WR of an accumulate run at base 50.
        preload(6'd50, 8'd10);
        preload(6'd51, 8'd20);
        preload(6'd52, 8'd30);
        preload(6'd53, 8'd40);
        issue(6'd50, 1'b1, 1'b0, 8'd1, 8'd1, 8'd1, 8'd1);
        step();
        start = 1'b0;
        check_out("t5.rd0", 1'b0, 6'd50, 8'd0, 1'b1, 1'b0);
        step();
        check_out("t5.wr0", 1'b1, 6'd50, 8'd11, 1'b1, 1'b0);
        exp_q.push_back({6'd50, 8'd11});
        step();
        check_out("t5.rd1", 1'b0, 6'd51, 8'd0, 1'b1, 1'b0);
        step();
        check_out("t5.wr1", 1'b1, 6'd51, 8'd21, 1'b1, 1'b0);
        exp_q.push_back({6'd51, 8'd21});
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_out("t5.rst", 1'b0, 6'd0, 8'd0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step();
            check_out($sformatf("t5.after%0d", i), 1'b0, 6'd0, 8'd0, 1'b0, 1'b0);
        end
        chk("t5.mem50", 32'(mem[50]), 32'd11);
        chk("t5.mem51", 32'(mem[51]), 32'd21);
        chk("t5.mem52", 32'(mem[52]), 32'd30);
        chk("t5.mem53", 32'(mem[53]), 32'd40);
        check_writes("t5");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
